zap_mem_inv_multiway: RTL and testbench

//  N-way RAM array with flip-flop valid bits per (way, index), for set-associative cache tag/data arrays.

---
 rtl/zap_mem_inv_multiway.sv | 137 +++++++++++++
 tb/tb_zap_mem_inv_multiway.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_mem_inv_multiway.sv
// N-way RAM array with flop valid bits, bulk/selective invalidate and a two-stage read pipeline
// with valid forwarding. Optional even-parity storage/check enabled by ZAP_MEM_INV_PARITY_EN.
module zap_mem_inv_multiway #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned WAYS  = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_clken,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [WAYS-1:0]          i_wen,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    input  logic                     i_inv,
    input  logic                     i_inv_one,
    input  logic [$clog2(DEPTH)-1:0] i_inv_addr,
    input  logic [WAYS-1:0]          i_inv_mask,
    output logic [WAYS*WIDTH-1:0]    o_rdata_pre,
    output logic [WAYS-1:0]          o_rdav_pre,
    output logic [WAYS*WIDTH-1:0]    o_rdata,
    output logic [WAYS-1:0]          o_rdav,
    output logic [WAYS-1:0]          o_perr
);
    localparam int unsigned AW = $clog2(DEPTH);
`ifdef ZAP_MEM_INV_PARITY_EN
    localparam int unsigned RW = WIDTH + 1;
`else
    localparam int unsigned RW = WIDTH;
`endif

    logic [DEPTH-1:0][WAYS-1:0] dav_q, dav_d;
    logic [AW-1:0]              s1_addr_q, s2_addr_q, s3_addr_q;
    logic [AW-1:0]              s1_addr_d, s2_addr_d, s3_addr_d;
    logic [WAYS-1:0]            s1_v_q, s2_v_q, s3_v_q;
    logic [WAYS-1:0]            s1_v_d, s2_v_d, s3_v_d;
    logic [RW-1:0]              wr_word;

    function automatic logic [WAYS-1:0] kill_m(input logic [AW-1:0] a);
        return i_inv_mask & {WAYS{i_inv_one && (i_inv_addr == a)}};
    endfunction

    // Invalidate wins over a write hitting the same (way, index).
    function automatic logic [WAYS-1:0] set_m(input logic [AW-1:0] a);
        return i_wen & {WAYS{i_clken && (i_waddr == a)}} & ~kill_m(a);
    endfunction

    function automatic logic [WAYS-1:0] fwd(input logic [AW-1:0] a, input logic [WAYS-1:0] pass);
        return (pass & ~kill_m(a)) | set_m(a);
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            dav_d[i] = fwd(AW'(i), dav_q[i]);
        end
        s1_addr_d = i_clken ? i_raddr   : s1_addr_q;
        s2_addr_d = i_clken ? s1_addr_q : s2_addr_q;
        s3_addr_d = i_clken ? s2_addr_q : s3_addr_q;
        s1_v_d    = fwd(s1_addr_d, i_clken ? dav_q[i_raddr] : s1_v_q);
        s2_v_d    = fwd(s2_addr_d, i_clken ? s1_v_q : s2_v_q);
        s3_v_d    = fwd(s3_addr_d, i_clken ? s2_v_q : s3_v_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_inv) begin
            dav_q     <= '0;
            s1_addr_q <= '0;
            s2_addr_q <= '0;
            s3_addr_q <= '0;
            s1_v_q    <= '0;
            s2_v_q    <= '0;
            s3_v_q    <= '0;
        end else begin
            dav_q     <= dav_d;
            s1_addr_q <= s1_addr_d;
            s2_addr_q <= s2_addr_d;
            s3_addr_q <= s3_addr_d;
            s1_v_q    <= s1_v_d;
            s2_v_q    <= s2_v_d;
            s3_v_q    <= s3_v_d;
        end
    end

    assign o_rdav_pre = s2_v_q;
    assign o_rdav     = s3_v_q;

`ifdef ZAP_MEM_INV_PARITY_EN
    logic [WAYS-1:0] rd_bad;
    logic [WAYS-1:0] perr_q, perr_d;
    assign wr_word = {^i_wdata, i_wdata};
`else
    assign wr_word = i_wdata;
`endif

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [RW-1:0]    mem_q [DEPTH];
        logic [RW-1:0]    rd_q;
        logic [WIDTH-1:0] d3_q;

        // Write-first read so a same-edge write lands in ST2 together with its forwarded valid.
        always_ff @(posedge i_clk) begin
            if (i_clken) begin
                if (i_wen[w]) begin
                    mem_q[i_waddr] <= wr_word;
                end
                rd_q <= (i_wen[w] && (i_waddr == s1_addr_q)) ? wr_word : mem_q[s1_addr_q];
                d3_q <= rd_q[WIDTH-1:0];
            end
        end

        assign o_rdata_pre[w*WIDTH +: WIDTH] = rd_q[WIDTH-1:0];
        assign o_rdata[w*WIDTH +: WIDTH]     = d3_q;
`ifdef ZAP_MEM_INV_PARITY_EN
        assign rd_bad[w] = ^rd_q;
`endif
    end

`ifdef ZAP_MEM_INV_PARITY_EN
    // Rows whose valid was set by an ST3 forward carry stale data, so they never flag.
    always_comb begin
        perr_d = s3_v_d & ~set_m(s3_addr_d) & (i_clken ? rd_bad : perr_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_inv) begin
            perr_q <= '0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign o_perr = perr_q;
`else
    assign o_perr = '0;
`endif

endmodule

// File: tb/tb_zap_mem_inv_multiway.sv
// Self-checking bench for zap_mem_inv_multiway: directed scenarios followed by random traffic,
// compared cycle by cycle against a rule-level reference model.
module tb_zap_mem_inv_multiway;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned WAYS  = 4;
    localparam int unsigned AW    = 5;
`ifdef ZAP_MEM_INV_PARITY_EN
    localparam bit Par = 1'b1;
`else
    localparam bit Par = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset, clken, inv, inv_one;
    logic [WIDTH-1:0]      wdata;
    logic [WAYS-1:0]       wen, inv_mask;
    logic [AW-1:0]         waddr, raddr, inv_addr;
    logic [WAYS*WIDTH-1:0] rdata_pre, rdata;
    logic [WAYS-1:0]       rdav_pre, rdav, perr;

    int checks   = 0;
    int failures = 0;

    // Reference state: array contents, valid bits, and the three in-flight read slots.
    logic [WIDTH-1:0] m_mem [WAYS][DEPTH];
    logic             m_bad [WAYS][DEPTH];
    logic [WAYS-1:0]  m_dav [DEPTH];
    logic [AW-1:0]    m_a   [1:3];
    logic [WAYS-1:0]  m_v   [1:3];
    logic [WIDTH-1:0] m_d2  [WAYS];
    logic [WIDTH-1:0] m_d3  [WAYS];
    logic [WAYS-1:0]  m_bad2, m_chk3, m_perr;

    zap_mem_inv_multiway #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH),
        .WAYS (WAYS)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_clken    (clken),
        .i_wdata    (wdata),
        .i_wen      (wen),
        .i_waddr    (waddr),
        .i_raddr    (raddr),
        .i_inv      (inv),
        .i_inv_one  (inv_one),
        .i_inv_addr (inv_addr),
        .i_inv_mask (inv_mask),
        .o_rdata_pre(rdata_pre),
        .o_rdav_pre (rdav_pre),
        .o_rdata    (rdata),
        .o_rdav     (rdav),
        .o_perr     (perr)
    );

    always #5 clk = ~clk;

    task automatic chk_v(input string tag, input logic [WAYS-1:0] obs, input logic [WAYS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [WAYS-1:0] killm(input logic [AW-1:0] a);
        logic [WAYS-1:0] r;
        for (int w = 0; w < WAYS; w++) r[w] = inv_one && inv_mask[w] && (inv_addr == a);
        return r;
    endfunction

    function automatic logic [WAYS-1:0] setm(input logic [AW-1:0] a);
        logic [WAYS-1:0] r;
        for (int w = 0; w < WAYS; w++) begin
            r[w] = !(inv_one && inv_mask[w] && (inv_addr == a)) && clken && wen[w] && (waddr == a);
        end
        return r;
    endfunction

    // Apply one clock edge of the specified behaviour to the model, using the current inputs.
    task automatic model_edge();
        logic [AW-1:0]   na [1:3];
        logic [WAYS-1:0] nv [1:3];
        logic [AW-1:0]   sa;
        logic [WAYS-1:0] sv, set3, bad3;
        for (int k = 1; k <= 3; k++) begin
            if (!clken) begin
                sa = m_a[k];
                sv = m_v[k];
            end else if (k == 1) begin
                sa = raddr;
                sv = m_dav[raddr];
            end else begin
                sa = m_a[k-1];
                sv = m_v[k-1];
            end
            na[k] = sa;
            nv[k] = (sv & ~killm(sa)) | setm(sa);
        end
        set3 = setm(na[3]);
        bad3 = m_bad2;
        if (clken) begin
            for (int w = 0; w < WAYS; w++) begin
                m_d3[w] = m_d2[w];
                if (wen[w] && waddr == m_a[1]) begin
                    m_d2[w]   = wdata;
                    m_bad2[w] = 1'b0;
                end else begin
                    m_d2[w]   = m_mem[w][m_a[1]];
                    m_bad2[w] = m_bad[w][m_a[1]];
                end
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            m_perr[w] = nv[3][w] && !set3[w] && (clken ? bad3[w] : m_perr[w]);
        end
        m_chk3 = clken ? ~set3 : m_chk3;
        for (int i = 0; i < DEPTH; i++) m_dav[i] = (m_dav[i] & ~killm(AW'(i))) | setm(AW'(i));
        for (int w = 0; w < WAYS; w++) begin
            if (clken && wen[w]) begin
                m_mem[w][waddr] = wdata;
                m_bad[w][waddr] = 1'b0;
            end
        end
        if (reset || inv) begin
            for (int i = 0; i < DEPTH; i++) m_dav[i] = '0;
            for (int k = 1; k <= 3; k++) begin
                na[k] = '0;
                nv[k] = '0;
            end
            m_perr = '0;
        end
        m_a = na;
        m_v = nv;
    endtask

    task automatic check_outputs();
        chk_v("rdav_pre", rdav_pre, m_v[2]);
        chk_v("rdav", rdav, m_v[3]);
        chk_v("perr", perr, Par ? m_perr : '0);
        for (int w = 0; w < WAYS; w++) begin
            if (m_v[2][w]) chk_d($sformatf("rdata_pre_w%0d", w), rdata_pre[w*WIDTH +: WIDTH], m_d2[w]);
            if (m_v[3][w] && m_chk3[w]) chk_d($sformatf("rdata_w%0d", w), rdata[w*WIDTH +: WIDTH], m_d3[w]);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        reset   = 1'b0;
        clken   = 1'b1;
        inv     = 1'b0;
        inv_one = 1'b0;
        wen     = '0;
    endtask

    initial begin
        for (int w = 0; w < WAYS; w++) begin
            for (int i = 0; i < DEPTH; i++) m_bad[w][i] = 1'b0;
        end
        idle();
        reset    = 1'b1;
        wdata    = '0;
        waddr    = '0;
        raddr    = '0;
        inv_addr = '0;
        inv_mask = '0;
        #2;
        step();
        step();

        // T1: read of an empty row after reset
        idle();
        raddr = 5;
        step();
        chk_v("t1_rdav_pre", rdav_pre, 4'b0000);
        step();
        chk_v("t1_rdav", rdav, 4'b0000);

        // T2: single-way write then read
        raddr = 0;
        wen   = 4'b0100;
        waddr = 5;
        wdata = 32'hDEADBEEF;
        step();
        wen   = '0;
        raddr = 5;
        step();
        raddr = 0;
        step();
        step();
        chk_v("t2_rdav", rdav, 4'b0100);
        chk_d("t2_rdata_w2", rdata[2*WIDTH +: WIDTH], 32'hDEADBEEF);

        // T3: write hits a read in ST2, then in ST3
        raddr = 7;
        step();
        raddr = 0;
        wen   = 4'b0010;
        waddr = 7;
        wdata = 32'h0000_0777;
        step();
        chk_v("t3_rdav_pre_fwd", rdav_pre, 4'b0010);
        wen      = '0;
        inv_one  = 1'b1;
        inv_addr = 7;
        inv_mask = 4'b0010;
        step();
        inv_one = 1'b0;
        raddr   = 7;
        step();
        raddr = 0;
        step();
        wen   = 4'b0010;
        waddr = 7;
        step();
        chk_v("t3_rdav_fwd", rdav, 4'b0010);
        wen = '0;

        // T4: fill idx 0..3, selectively invalidate idx 2 ways 1 and 3
        for (int i = 0; i < 4; i++) begin
            wen   = 4'b1111;
            waddr = AW'(i);
            wdata = $urandom;
            step();
        end
        wen      = '0;
        inv_one  = 1'b1;
        inv_addr = 2;
        inv_mask = 4'b1010;
        step();
        inv_one = 1'b0;
        for (int i = 0; i < 4; i++) begin
            raddr = AW'(i);
            step();
            step();
            step();
            chk_v($sformatf("t4_rdav_idx%0d", i), rdav, (i == 2) ? 4'b0101 : 4'b1111);
        end

        // T5: invalidate beats write on the same bit; bulk invalidate while clock-disabled
        wen      = 4'b0001;
        waddr    = 9;
        inv_one  = 1'b1;
        inv_addr = 9;
        inv_mask = 4'b0001;
        step();
        idle();
        raddr = 9;
        step();
        step();
        step();
        chk_v("t5_rdav_idx9", rdav, 4'b0000);
        raddr = 0;
        step();
        step();
        chk_v("t5_rdav_pre_before_inv", rdav_pre, 4'b1111);
        clken = 1'b0;
        inv   = 1'b1;
        step();
        chk_v("t5_rdav_after_inv", rdav, 4'b0000);
        chk_v("t5_rdav_pre_after_inv", rdav_pre, 4'b0000);
        idle();
        step();
        step();
        step();
        chk_v("t5_rdav_later", rdav, 4'b0000);

        // T6: corrupt one stored bit of way 3 idx 4
        wen   = 4'b1111;
        waddr = 4;
        wdata = 32'h1234_5678;
        step();
        wen = '0;
`ifdef ZAP_MEM_INV_PARITY_EN
        dut.g_way[3].mem_q[4][0] = ~dut.g_way[3].mem_q[4][0];
        m_mem[3][4][0] = ~m_mem[3][4][0];
        m_bad[3][4]    = 1'b1;
`endif
        raddr = 4;
        step();
        step();
        step();
        chk_v("t6_rdav", rdav, 4'b1111);
        chk_v("t6_perr", perr, Par ? 4'b1000 : 4'b0000);

        // Random traffic on a narrow index range to provoke collisions
        for (int n = 0; n < 800; n++) begin
            reset    = ($urandom_range(0, 199) == 0);
            clken    = ($urandom_range(0, 4) != 0);
            wen      = 4'($urandom) & 4'($urandom);
            waddr    = AW'($urandom_range(0, 7));
            raddr    = AW'($urandom_range(0, 7));
            wdata    = $urandom;
            inv      = ($urandom_range(0, 79) == 0);
            inv_one  = ($urandom_range(0, 5) == 0);
            inv_addr = AW'($urandom_range(0, 7));
            inv_mask = 4'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
